// File: rtl/store_buffer_if.sv
// Store, load-forward and dcache write-port signals of the store buffer.
// The slave side is the buffer; the master side is the pipeline/dcache.
interface store_buffer_if #(
  parameter int ADR_W = 12
);
  logic             st_valid;
  logic [ADR_W-1:0] st_adr;
  logic [3:0]       st_we;
  logic [31:0]      st_data;
  logic             st_ready;
  logic             ld_valid;
  logic [ADR_W-1:0] ld_adr;
  logic [31:0]      dc_rdata;
  logic [31:0]      ld_data;
  logic             dc_ready;
  logic [3:0]       dc_we;
  logic [ADR_W-1:0] dc_adr;
  logic [31:0]      dc_din;
  logic             empty;

  modport slave (
    input  st_valid, st_adr, st_we, st_data,
    input  ld_valid, ld_adr, dc_rdata, dc_ready,
    output st_ready, ld_data, dc_we, dc_adr, dc_din, empty
  );

  modport master (
    output st_valid, st_adr, st_we, st_data,
    output ld_valid, ld_adr, dc_rdata, dc_ready,
    input  st_ready, ld_data, dc_we, dc_adr, dc_din, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store queue with same-word write combining and
// byte-lane load forwarding ahead of the dcache write port.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int ADR_W = 12
) (
  input logic          clk,
  input logic          rst,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADR_W-1:0] e_adr  [DEPTH];
  logic [3:0]       e_we   [DEPTH];
  logic [31:0]      e_data [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] yng;
  logic [CW-1:0] count;

  logic push;
  logic pop;
  logic comb;

  logic [3:0]  fwd_v;
  logic [31:0] fwd_d;
  logic [3:0]  snap_v;
  logic [31:0] snap_d;

  assign yng  = tail - PW'(1);
  assign pop  = (count != '0) && bus.dc_ready;
  assign push = bus.st_valid && (bus.st_we != 4'b0000) && bus.st_ready;

  // Combine only if the youngest entry survives this edge.
  assign comb = push && (count != '0) &&
                (e_adr[yng] == bus.st_adr) &&
                !(pop && (count == CW'(1)));

  assign bus.st_ready = (count != CW'(DEPTH));
  assign bus.empty    = (count == '0);
  assign bus.dc_we    = (pop && !rst) ? e_we[head] : 4'b0000;
  assign bus.dc_adr   = e_adr[head];
  assign bus.dc_din   = e_data[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_we[i]   <= 4'b0000;
        e_adr[i]  <= '0;
        e_data[i] <= '0;
      end
    end else begin
      if (comb) begin
        e_we[yng] <= e_we[yng] | bus.st_we;
        for (int l = 0; l < 4; l++) begin
          if (bus.st_we[l])
            e_data[yng][8*l +: 8] <= bus.st_data[8*l +: 8];
        end
      end else if (push) begin
        e_adr[tail]  <= bus.st_adr;
        e_we[tail]   <= bus.st_we;
        e_data[tail] <= bus.st_data;
        tail         <= tail + PW'(1);
      end
      if (pop)
        head <= head + PW'(1);
      count <= count
             + CW'(push && !comb)
             - CW'(pop);
    end
  end

  // Oldest to youngest so later stores override earlier ones.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_v = 4'b0000;
    fwd_d = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (e_adr[idx] == bus.ld_adr)) begin
        for (int l = 0; l < 4; l++) begin
          if (e_we[idx][l]) begin
            fwd_v[l]         = 1'b1;
            fwd_d[8*l +: 8]  = e_data[idx][8*l +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_v <= 4'b0000;
      snap_d <= '0;
    end else begin
      snap_v <= bus.ld_valid ? fwd_v : 4'b0000;
      snap_d <= fwd_d;
    end
  end

  always_comb begin
    bus.ld_data = bus.dc_rdata;
    for (int l = 0; l < 4; l++) begin
      if (snap_v[l])
        bus.ld_data[8*l +: 8] = snap_d[8*l +: 8];
    end
  end
endmodule
